alu_rr_scheduler: RTL and testbench

- Shares one N-bit ALU between two requesters using round-robin arbitration and valid/ready handshakes.
- Registers each operation's result into a one-deep output stage, tagged with the requester ID.
- Sits between two command sources, such as a sequencer and a debug port, and a single downstream result consumer.
- Contains the ALU function internally. Opcode encoding matches the team's standard 8-op ALU.

---
 rtl/alu_rr_scheduler_if.sv | 42 ++++
 rtl/alu_rr_scheduler.sv | 141 ++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rr_scheduler_if.sv
// Handshake bundle between two command sources, the shared-ALU scheduler
// and one result consumer.
// Optional: ALU_RR_ZERO_FLAG_EN adds the rsp_zero result flag.
interface alu_rr_scheduler_if #(
    parameter int N = 4
);
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [N-1:0] req_a0;
    logic [N-1:0] req_b0;
    logic [2:0]   req_sel0;
    logic [N-1:0] req_a1;
    logic [N-1:0] req_b1;
    logic [2:0]   req_sel1;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N:0]   rsp_out;
    logic         rsp_id;
`ifdef ALU_RR_ZERO_FLAG_EN
    logic         rsp_zero;
`endif

    // Command sources and result consumer
    modport master (
`ifdef ALU_RR_ZERO_FLAG_EN
        input  rsp_zero,
`endif
        output req_valid, req_a0, req_b0, req_sel0, req_a1, req_b1, req_sel1,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_id
    );

    // Scheduler side
    modport slave (
`ifdef ALU_RR_ZERO_FLAG_EN
        output rsp_zero,
`endif
        input  req_valid, req_a0, req_b0, req_sel0, req_a1, req_b1, req_sel1,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_id
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one N-bit ALU between two requesters.
// Results are registered in a one-deep output stage tagged with the
// requester ID. Optional: ALU_RR_ZERO_FLAG_EN adds a registered rsp_zero flag.
module alu_rr_scheduler #(
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    alu_rr_scheduler_if.slave  bus,
    output logic [CNT_W-1:0]   op_count
);

    // Team 8-op ALU; operands zero-extended to N+1 bits, result wraps mod 2^(N+1)
    function automatic logic [N:0] alu_f(input logic [N-1:0] a,
                                         input logic [N-1:0] b,
                                         input logic [2:0]   sel);
        logic [N:0] ax;
        logic [N:0] bx;
        logic [N:0] one;
        ax  = {1'b0, a};
        bx  = {1'b0, b};
        one = {{N{1'b0}}, 1'b1};
        case (sel)
            3'b000:  alu_f = ax + bx;
            3'b001:  alu_f = ax - bx;
            3'b010:  alu_f = ax + one;
            3'b011:  alu_f = ax - one;
            3'b100:  alu_f = ax & bx;
            3'b101:  alu_f = ax | bx;
            3'b110:  alu_f = ax ^ bx;
            3'b111:  alu_f = ~ax;
            default: alu_f = {(N+1){1'b0}};
        endcase
    endfunction

    logic             rsp_valid_q, rsp_valid_d;
    logic [N:0]       rsp_out_q,   rsp_out_d;
    logic             rsp_id_q,    rsp_id_d;
    logic             last_q,      last_d;
    logic [CNT_W-1:0] op_count_q,  op_count_d;
`ifdef ALU_RR_ZERO_FLAG_EN
    logic             rsp_zero_q,  rsp_zero_d;
`endif

    logic [1:0]   grant_s;
    logic         accept_s;
    logic [1:0]   ready_s;
    logic         xfer_s;
    logic [N-1:0] op_a_s;
    logic [N-1:0] op_b_s;
    logic [2:0]   op_sel_s;
    logic [N:0]   alu_res_s;

    // Round-robin grant: a lone requester wins; on contention the one that did not go last wins
    always_comb begin
        grant_s = 2'b00;
        case (bus.req_valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = last_q ? 2'b01 : 2'b10;
            default: grant_s = 2'b00;
        endcase
    end

    // Acceptance when the output stage is empty or drains this cycle; pick the granted operands
    always_comb begin
        accept_s = bus.rsp_ready | ~rsp_valid_q;
        ready_s  = grant_s & {2{accept_s}};
        xfer_s   = |(ready_s & bus.req_valid);
        if (grant_s[1]) begin
            op_a_s   = bus.req_a1;
            op_b_s   = bus.req_b1;
            op_sel_s = bus.req_sel1;
        end else begin
            op_a_s   = bus.req_a0;
            op_b_s   = bus.req_b0;
            op_sel_s = bus.req_sel0;
        end
        alu_res_s = alu_f(op_a_s, op_b_s, op_sel_s);
    end

    // Next state: load on transfer, clear on a plain drain, otherwise hold
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_out_d   = rsp_out_q;
        rsp_id_d    = rsp_id_q;
        last_d      = last_q;
        op_count_d  = op_count_q;
`ifdef ALU_RR_ZERO_FLAG_EN
        rsp_zero_d  = rsp_zero_q;
`endif
        if (xfer_s) begin
            rsp_valid_d = 1'b1;
            rsp_out_d   = alu_res_s;
            rsp_id_d    = grant_s[1];
            last_d      = grant_s[1];
            op_count_d  = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef ALU_RR_ZERO_FLAG_EN
            rsp_zero_d  = (alu_res_s == {(N+1){1'b0}});
`endif
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // State registers; reset discards any held result and restores priority to requester 0
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= {(N+1){1'b0}};
            rsp_id_q    <= 1'b0;
            last_q      <= 1'b1;
            op_count_q  <= {CNT_W{1'b0}};
`ifdef ALU_RR_ZERO_FLAG_EN
            rsp_zero_q  <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_out_q   <= rsp_out_d;
            rsp_id_q    <= rsp_id_d;
            last_q      <= last_d;
            op_count_q  <= op_count_d;
`ifdef ALU_RR_ZERO_FLAG_EN
            rsp_zero_q  <= rsp_zero_d;
`endif
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_id    = rsp_id_q;
    assign op_count      = op_count_q;
`ifdef ALU_RR_ZERO_FLAG_EN
    assign bus.rsp_zero  = rsp_zero_q;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: directed scenarios followed by
// randomized traffic, checked against a behavioural reference model.
module tb_alu_rr_scheduler;
    localparam int N     = 4;
    localparam int CNT_W = 16;
    localparam int RMASK = (1 << (N + 1)) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CNT_W-1:0] op_count;

    alu_rr_scheduler_if #(.N(N)) bus();

    alu_rr_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        int id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_last  = 1;
    int m_count = 0;
    bit m_rv    = 1'b0;
    bit pend[2] = '{1'b0, 1'b0};

    function automatic int ref_alu(int a, int b, int sel);
        int r;
        case (sel)
            0: r = a + b;
            1: r = a - b;
            2: r = a + 1;
            3: r = a - 1;
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            7: r = ~a;
            default: r = 0;
        endcase
        return r & RMASK;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic set_req(input int i, input bit v, input int a, input int b, input int sel);
        if (i == 0) begin
            bus.req_valid[0] = v;
            bus.req_a0       = a[N-1:0];
            bus.req_b0       = b[N-1:0];
            bus.req_sel0     = sel[2:0];
        end else begin
            bus.req_valid[1] = v;
            bus.req_a1       = a[N-1:0];
            bus.req_b1       = b[N-1:0];
            bus.req_sel1     = sel[2:0];
        end
    endtask

    // One clock cycle: inputs already driven at the falling edge
    task automatic step();
        bit was_rst;
        int v0, v1, g, exp_rdy, a, b, s;
        bit accept;
        #1;
        was_rst = rst;
        if (!was_rst) begin
            chk("op_count", int'(op_count), m_count);
            chk("rsp_valid", int'(bus.rsp_valid), int'(m_rv));
            v0 = int'(bus.req_valid[0]);
            v1 = int'(bus.req_valid[1]);
            if (v0 == 1 && v1 == 0)      g = 0;
            else if (v0 == 0 && v1 == 1) g = 1;
            else if (v0 == 1 && v1 == 1) g = (m_last == 0) ? 1 : 0;
            else                         g = -1;
            accept  = bus.rsp_ready || !m_rv;
            exp_rdy = (g >= 0 && accept) ? (1 << g) : 0;
            chk("req_ready", int'(bus.req_ready), exp_rdy);
            if (exp_rdy != 0) begin
                a = (g == 1) ? int'(bus.req_a1)   : int'(bus.req_a0);
                b = (g == 1) ? int'(bus.req_b1)   : int'(bus.req_b0);
                s = (g == 1) ? int'(bus.req_sel1) : int'(bus.req_sel0);
                exp_q.push_back('{res: ref_alu(a, b, s), id: g});
                m_last  = g;
                m_count = (m_count + 1) % (1 << CNT_W);
                m_rv    = 1'b1;
            end else if (m_rv && bus.rsp_ready) begin
                m_rv = 1'b0;
            end
            pend[0] = (v0 == 1) && !(exp_rdy != 0 && g == 0);
            pend[1] = (v1 == 1) && !(exp_rdy != 0 && g == 1);
        end
        @(negedge clk);
        if (was_rst) begin
            exp_q.delete();
            m_rv    = 1'b0;
            m_count = 0;
            m_last  = 1;
            pend    = '{1'b0, 1'b0};
        end
    endtask

    // Monitor: compare the presented result against the oldest expected entry
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got out=%0d id=%0d expected no result at %0t",
                             bus.rsp_out, bus.rsp_id, $time);
                end else begin
                    chk("rsp_out", int'(bus.rsp_out), exp_q[0].res);
                    chk("rsp_id", int'(bus.rsp_id), exp_q[0].id);
`ifdef ALU_RR_ZERO_FLAG_EN
                    chk("rsp_zero", int'(bus.rsp_zero), (exp_q[0].res == 0) ? 1 : 0);
`endif
                    if (bus.rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus
    initial begin
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);

        // Reset held two cycles with both requests valid
        set_req(0, 1'b1, 9, 8, 0);
        set_req(1, 1'b1, 3, 3, 0);
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rsp_out_reset", int'(bus.rsp_out), 0);
        chk("rsp_id_reset", int'(bus.rsp_id), 0);

        // Continuous contention: 3-5 from requester 0, ~5 from requester 1
        set_req(0, 1'b1, 3, 5, 1);
        set_req(1, 1'b1, 5, 0, 7);
        repeat (4) step();
        set_req(0, 1'b0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0);
        step();

        // Single request with carry: 9+8
        set_req(0, 1'b1, 9, 8, 0);
        step();
        set_req(0, 1'b0, 0, 0, 0);
        step();

        // Backpressure with requester 1 waiting
        set_req(0, 1'b1, 2, 3, 0);
        bus.rsp_ready = 1'b0;
        step();
        set_req(0, 1'b0, 0, 0, 0);
        set_req(1, 1'b1, 7, 1, 1);
        repeat (3) step();
        bus.rsp_ready = 1'b1;
        step();
        set_req(1, 1'b0, 0, 0, 0);
        step();
        step();

        // Reset while a result is held under backpressure
        set_req(0, 1'b1, 1, 1, 0);
        bus.rsp_ready = 1'b0;
        step();
        set_req(0, 1'b0, 0, 0, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        step();

        // Zero result then all-ones result: 6^6, dec 0
        set_req(0, 1'b1, 6, 6, 6);
        step();
        set_req(0, 1'b1, 0, 0, 3);
        step();
        set_req(0, 1'b0, 0, 0, 0);
        step();

        // Randomized traffic; a waiting requester keeps its command stable
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    set_req(i, ($urandom_range(0, 99) < 60),
                            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                            int'($urandom_range(0, 7)));
                end
            end
            bus.rsp_ready = ($urandom_range(0, 99) < 65);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end

        // Drain everything still in flight
        rst = 1'b0;
        set_req(0, 1'b0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0);
        bus.rsp_ready = 1'b1;
        repeat (3) step();
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
